anim_controller: RTL and testbench

//  Per-fighter animation sequencer; sits directly upstream of sprite_mapper and drives its anim_state/anim_frame.

---
 rtl/anim_pkg.sv | 23 ++
 rtl/anim_frame_timer.sv | 78 +++++++
 rtl/anim_controller.sv | 174 +++++++++++++++++
 tb/tb_anim_controller.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/anim_pkg.sv
// Encodings shared between the animation sequencer and sprite_mapper.
package anim_pkg;

  typedef enum logic [3:0] {
    ANIM_IDLE = 4'd0,
    ANIM_WALK = 4'd1,
    ANIM_JUMP = 4'd2,
    ANIM_ATK1 = 4'd3,
    ANIM_ATK2 = 4'd4,
    ANIM_HIT  = 4'd5
  } anim_state_e;

  localparam logic FACING_RIGHT = 1'b0;
  localparam logic FACING_LEFT  = 1'b1;

  localparam int FRAME_W = 6;

  // Bits needed to hold 0..max_val, never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/anim_frame_timer.sv
// Attack frame timer: divides frame_tick by TICKS_PER_FRAME and steps the frame index
// until the latched frame count is exhausted.
module anim_frame_timer
  import anim_pkg::*;
#(
  parameter int TICKS_PER_FRAME = 4,
  parameter int ACTIVE_FRAME    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               start,
  input  logic               abort,
  input  logic [FRAME_W-1:0] num_frames,
  output logic [FRAME_W-1:0] frame,
  output logic               active,
  output logic               wrap,
  output logic               last
);

  localparam int TW = cnt_width(TICKS_PER_FRAME - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_FRAME - 1);

  logic               running;
  logic               run_nxt;
  logic [TW-1:0]      tick_cnt;
  logic [TW-1:0]      cnt_nxt;
  logic [FRAME_W-1:0] frame_nxt;
  logic [FRAME_W-1:0] n_frames;

  // wrap/last are combinational so the owner can act on the same frame_tick.
  assign wrap = tick && running && (tick_cnt == TICK_LAST);
  assign last = wrap && (frame == n_frames - FRAME_W'(1));

  always_comb begin
    run_nxt   = running;
    cnt_nxt   = tick_cnt;
    frame_nxt = frame;
    if (abort) begin
      run_nxt   = 1'b0;
      cnt_nxt   = '0;
      frame_nxt = '0;
    end else if (start) begin
      run_nxt   = 1'b1;
      cnt_nxt   = '0;
      frame_nxt = '0;
    end else if (tick && running) begin
      if (wrap) begin
        cnt_nxt = '0;
        if (last) begin
          run_nxt   = 1'b0;
          frame_nxt = '0;
        end else begin
          frame_nxt = frame + FRAME_W'(1);
        end
      end else begin
        cnt_nxt = tick_cnt + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running  <= 1'b0;
      tick_cnt <= '0;
      frame    <= '0;
      n_frames <= '0;
      active   <= 1'b0;
    end else begin
      running  <= run_nxt;
      tick_cnt <= cnt_nxt;
      frame    <= frame_nxt;
      active   <= run_nxt && (frame_nxt == FRAME_W'(ACTIVE_FRAME));
      if (start) n_frames <= num_frames;
    end
  end

endmodule

// File: rtl/anim_controller.sv
// Per-fighter animation sequencer: latches intents/hits between frame ticks and
// steps the animation state once per frame_tick with hit > atk1 > atk2 > jump > move.
module anim_controller
  import anim_pkg::*;
#(
  parameter int TICKS_PER_FRAME  = 4,
  parameter int ATK1_FRAMES      = 6,
  parameter int ATK2_FRAMES      = 8,
  parameter int ATK_ACTIVE_FRAME = 2,
  parameter int HITSTUN_TICKS    = 20,
  parameter int MIN_AIR_TICKS    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               move_left,
  input  logic               move_right,
  input  logic               jump_req,
  input  logic               atk1_req,
  input  logic               atk2_req,
  input  logic               hit,
  input  logic               on_ground,
  output logic [3:0]         anim_state,
  output logic [FRAME_W-1:0] anim_frame,
  output logic               facing,
  output logic               busy,
  output logic               atk_active,
  output logic               anim_done
);

  localparam int HW = cnt_width(HITSTUN_TICKS);
  localparam int AW = cnt_width(MIN_AIR_TICKS);
  localparam logic [HW-1:0] HIT_RELOAD = HW'(HITSTUN_TICKS);
  localparam logic [AW-1:0] AIR_MIN    = AW'(MIN_AIR_TICKS);

  anim_state_e   state;
  logic [HW-1:0] hit_cnt;
  logic [AW-1:0] air_cnt;
  logic          jump_pend, atk1_pend, atk2_pend, hit_pend;

  // Pending flags plus a pulse coincident with the tick both count.
  logic eff_jump, eff_atk1, eff_atk2, eff_hit;
  assign eff_jump = jump_pend | jump_req;
  assign eff_atk1 = atk1_pend | atk1_req;
  assign eff_atk2 = atk2_pend | atk2_req;
  assign eff_hit  = hit_pend  | hit;

  logic ground_ready, take_hit, take_atk1, take_atk2;
  assign ground_ready = ((state == ANIM_IDLE) || (state == ANIM_WALK)) && on_ground;
  assign take_hit     = frame_tick && eff_hit;
  assign take_atk1    = frame_tick && !eff_hit && ground_ready && eff_atk1;
  assign take_atk2    = frame_tick && !eff_hit && ground_ready && !eff_atk1 && eff_atk2;

  logic        one_move;
  anim_state_e settle_state;
  logic        move_facing;
  assign one_move     = move_left ^ move_right;
  assign settle_state = one_move ? ANIM_WALK : ANIM_IDLE;
  assign move_facing  = move_left ? FACING_LEFT : FACING_RIGHT;

  logic               tmr_wrap, tmr_last;
  logic [FRAME_W-1:0] tmr_frames;
  assign tmr_frames = take_atk1 ? FRAME_W'(ATK1_FRAMES) : FRAME_W'(ATK2_FRAMES);

  anim_frame_timer #(
    .TICKS_PER_FRAME(TICKS_PER_FRAME),
    .ACTIVE_FRAME   (ATK_ACTIVE_FRAME)
  ) u_timer (
    .clk       (clk),
    .rst       (reset),
    .tick      (frame_tick),
    .start     (take_atk1 || take_atk2),
    .abort     (take_hit),
    .num_frames(tmr_frames),
    .frame     (anim_frame),
    .active    (atk_active),
    .wrap      (tmr_wrap),
    .last      (tmr_last)
  );

  assign anim_state = state;

  // Every request is judged on the next tick and then forgotten, accepted or not.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      jump_pend <= 1'b0;
      atk1_pend <= 1'b0;
      atk2_pend <= 1'b0;
      hit_pend  <= 1'b0;
    end else if (frame_tick) begin
      jump_pend <= 1'b0;
      atk1_pend <= 1'b0;
      atk2_pend <= 1'b0;
      hit_pend  <= 1'b0;
    end else begin
      jump_pend <= jump_pend | jump_req;
      atk1_pend <= atk1_pend | atk1_req;
      atk2_pend <= atk2_pend | atk2_req;
      hit_pend  <= hit_pend  | hit;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ANIM_IDLE;
      facing    <= FACING_RIGHT;
      busy      <= 1'b0;
      anim_done <= 1'b0;
      hit_cnt   <= '0;
      air_cnt   <= '0;
    end else begin
      anim_done <= 1'b0;
      if (frame_tick) begin
        if (eff_hit) begin
          state   <= ANIM_HIT;
          busy    <= 1'b1;
          hit_cnt <= HIT_RELOAD;
        end else begin
          case (state)
            ANIM_IDLE, ANIM_WALK: begin
              if (!on_ground) begin
                state   <= ANIM_JUMP;
                air_cnt <= '0;
              end else if (eff_atk1) begin
                state <= ANIM_ATK1;
                busy  <= 1'b1;
              end else if (eff_atk2) begin
                state <= ANIM_ATK2;
                busy  <= 1'b1;
              end else if (eff_jump) begin
                state   <= ANIM_JUMP;
                air_cnt <= '0;
              end else begin
                state <= settle_state;
                if (one_move) facing <= move_facing;
              end
            end
            ANIM_ATK1, ANIM_ATK2: begin
              if (tmr_last) begin
                state     <= settle_state;
                busy      <= 1'b0;
                anim_done <= 1'b1;
                if (one_move) facing <= move_facing;
              end
            end
            ANIM_JUMP: begin
              if (on_ground && (air_cnt == AIR_MIN)) begin
                state <= settle_state;
                if (one_move) facing <= move_facing;
              end else if (air_cnt != AIR_MIN) begin
                air_cnt <= air_cnt + AW'(1);
              end
            end
            ANIM_HIT: begin
              if (hit_cnt <= HW'(1)) begin
                state     <= on_ground ? ANIM_IDLE : ANIM_JUMP;
                air_cnt   <= '0;
                busy      <= 1'b0;
                anim_done <= 1'b1;
              end else begin
                hit_cnt <= hit_cnt - HW'(1);
              end
            end
            default: begin
              state <= ANIM_IDLE;
              busy  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_anim_controller.sv
// Directed bench for anim_controller: each step pushes its expected output word,
// drives one frame_tick, then pops and compares against the registered outputs.
module tb_anim_controller;

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_WALK = 4'd1;
  localparam logic [3:0] S_JUMP = 4'd2;
  localparam logic [3:0] S_ATK1 = 4'd3;
  localparam logic [3:0] S_ATK2 = 4'd4;
  localparam logic [3:0] S_HIT  = 4'd5;

  // pulse mask bit order: {hit, atk1, atk2, jump}
  localparam logic [3:0] P_NONE = 4'b0000;
  localparam logic [3:0] P_HIT  = 4'b1000;
  localparam logic [3:0] P_ATK1 = 4'b0100;
  localparam logic [3:0] P_ATK2 = 4'b0010;
  localparam logic [3:0] P_JUMP = 4'b0001;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick, move_left, move_right;
  logic       jump_req, atk1_req, atk2_req, hit, on_ground;
  logic [3:0] anim_state;
  logic [5:0] anim_frame;
  logic       facing, busy, atk_active, anim_done;

  logic [15:0] exp_q[$];
  int          n_cmp = 0;
  int          n_mis = 0;
  logic        fcx;

  anim_controller dut (
    .clk       (clk),
    .reset     (reset),
    .frame_tick(frame_tick),
    .move_left (move_left),
    .move_right(move_right),
    .jump_req  (jump_req),
    .atk1_req  (atk1_req),
    .atk2_req  (atk2_req),
    .hit       (hit),
    .on_ground (on_ground),
    .anim_state(anim_state),
    .anim_frame(anim_frame),
    .facing    (facing),
    .busy      (busy),
    .atk_active(atk_active),
    .anim_done (anim_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] pack(input logic [3:0] st, input int fr, input logic fc,
                                       input logic bz, input logic aa, input logic ad);
    return {st, 6'(fr), fc, bz, aa, ad, 2'b00};
  endfunction

  task automatic sb_check(input string tag);
    logic [15:0] o, e;
    o = pack(anim_state, int'(anim_frame), facing, busy, atk_active, anim_done);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL %s: scoreboard empty, got %h", tag, o);
      return;
    end
    e = exp_q.pop_front();
    n_cmp++;
    assert (o === e) else begin
      n_mis++;
      $error("FAIL %s: got st=%0d fr=%0d fc=%b bz=%b aa=%b ad=%b, expected st=%0d fr=%0d fc=%b bz=%b aa=%b ad=%b",
             tag, o[15:12], o[11:6], o[5], o[4], o[3], o[2],
             e[15:12], e[11:6], e[5], e[4], e[3], e[2]);
    end
  endtask

  task automatic pulse(input logic [3:0] pul);
    @(negedge clk);
    {hit, atk1_req, atk2_req, jump_req} = pul;
    @(negedge clk);
    {hit, atk1_req, atk2_req, jump_req} = 4'b0000;
  endtask

  task automatic step(input logic [3:0] pul, input logic [3:0] st, input int fr, input logic fc,
                      input logic bz, input logic aa, input logic ad, input string tag);
    exp_q.push_back(pack(st, fr, fc, bz, aa, ad));
    @(negedge clk);
    frame_tick = 1'b1;
    {hit, atk1_req, atk2_req, jump_req} = pul;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    {hit, atk1_req, atk2_req, jump_req} = 4'b0000;
    sb_check(tag);
  endtask

  initial begin
    reset = 1'b1;
    frame_tick = 1'b0;
    move_left = 1'b0;
    move_right = 1'b0;
    {hit, atk1_req, atk2_req, jump_req} = 4'b0000;
    on_ground = 1'b1;
    fcx = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(pack(S_IDLE, 0, 0, 0, 0, 0));
    sb_check("reset_values");
    @(negedge clk);
    reset = 1'b0;

    // Walking and facing
    move_left = 1'b1;
    step(P_NONE, S_WALK, 0, 1'b1, 0, 0, 0, "walk_left");
    move_right = 1'b1;
    step(P_NONE, S_IDLE, 0, 1'b1, 0, 0, 0, "both_moves_idle");
    move_left = 1'b0;
    step(P_NONE, S_WALK, 0, 1'b0, 0, 0, 0, "walk_right");
    move_right = 1'b0;
    step(P_NONE, S_IDLE, 0, 1'b0, 0, 0, 0, "no_move_idle");

    // Full ATK1: 6 frames of 4 ticks, active on frame 2
    pulse(P_ATK1);
    step(P_NONE, S_ATK1, 0, fcx, 1, 0, 0, "atk1_entry");
    for (int k = 1; k < 24; k++)
      step(P_NONE, S_ATK1, k / 4, fcx, 1, (k / 4) == 2, 0, "atk1_frame");
    step(P_NONE, S_IDLE, 0, fcx, 0, 0, 1, "atk1_done");
    @(posedge clk);
    #1;
    exp_q.push_back(pack(S_IDLE, 0, fcx, 0, 0, 0));
    sb_check("done_one_cycle");

    // ATK1 and ATK2 together: ATK1 wins, ATK2 dropped; exit into WALK
    pulse(P_ATK1 | P_ATK2);
    step(P_NONE, S_ATK1, 0, fcx, 1, 0, 0, "dual_req_atk1");
    for (int k = 1; k < 24; k++)
      step(P_NONE, S_ATK1, k / 4, fcx, 1, (k / 4) == 2, 0, "dual_atk1_frame");
    move_left = 1'b1;
    fcx = 1'b1;
    step(P_NONE, S_WALK, 0, fcx, 0, 0, 1, "atk1_exit_walk");
    step(P_NONE, S_WALK, 0, fcx, 0, 0, 0, "no_atk2_after");
    move_left = 1'b0;
    step(P_NONE, S_IDLE, 0, fcx, 0, 0, 0, "idle_after_walk");

    // Hit on tick 10 of ATK2, then full hitstun
    pulse(P_ATK2);
    step(P_NONE, S_ATK2, 0, fcx, 1, 0, 0, "atk2_entry");
    for (int k = 1; k < 10; k++)
      step(P_NONE, S_ATK2, k / 4, fcx, 1, (k / 4) == 2, 0, "atk2_frame");
    step(P_HIT, S_HIT, 0, fcx, 1, 0, 0, "hit_aborts_atk2");
    for (int k = 1; k < 20; k++)
      step(P_NONE, S_HIT, 0, fcx, 1, 0, 0, "hitstun");
    step(P_NONE, S_IDLE, 0, fcx, 0, 0, 1, "hitstun_done");

    // Jump on ground: two air ticks, attack in air rejected
    pulse(P_JUMP);
    step(P_NONE, S_JUMP, 0, fcx, 0, 0, 0, "jump_entry");
    step(P_NONE, S_JUMP, 0, fcx, 0, 0, 0, "jump_air1");
    pulse(P_ATK1);
    step(P_NONE, S_JUMP, 0, fcx, 0, 0, 0, "jump_air2_atk_rej");
    step(P_NONE, S_IDLE, 0, fcx, 0, 0, 0, "jump_land");
    step(P_NONE, S_IDLE, 0, fcx, 0, 0, 0, "atk_not_carried");

    // Walking off a ledge, landing only once on_ground returns
    on_ground = 1'b0;
    step(P_NONE, S_JUMP, 0, fcx, 0, 0, 0, "ledge_fall");
    for (int k = 0; k < 3; k++)
      step(P_NONE, S_JUMP, 0, fcx, 0, 0, 0, "airborne");
    on_ground = 1'b1;
    step(P_NONE, S_IDLE, 0, fcx, 0, 0, 0, "ledge_land");

    // Hit in the air, re-hit restarts the count, exit into JUMP
    on_ground = 1'b0;
    step(P_HIT, S_HIT, 0, fcx, 1, 0, 0, "air_hit");
    for (int k = 0; k < 5; k++)
      step(P_NONE, S_HIT, 0, fcx, 1, 0, 0, "air_hitstun");
    step(P_HIT, S_HIT, 0, fcx, 1, 0, 0, "rehit");
    for (int k = 1; k < 20; k++)
      step(P_NONE, S_HIT, 0, fcx, 1, 0, 0, "rehit_stun");
    step(P_NONE, S_JUMP, 0, fcx, 0, 0, 1, "hit_exit_air");
    on_ground = 1'b1;
    step(P_NONE, S_JUMP, 0, fcx, 0, 0, 0, "post_hit_air1");
    step(P_NONE, S_JUMP, 0, fcx, 0, 0, 0, "post_hit_air2");
    step(P_NONE, S_IDLE, 0, fcx, 0, 0, 0, "post_hit_land");

    // Async reset mid-ATK1 with a pending request that must be discarded
    pulse(P_ATK1);
    step(P_NONE, S_ATK1, 0, fcx, 1, 0, 0, "atk1_again");
    for (int k = 1; k < 10; k++)
      step(P_NONE, S_ATK1, k / 4, fcx, 1, (k / 4) == 2, 0, "atk1_before_reset");
    @(negedge clk);
    atk1_req = 1'b1;
    @(negedge clk);
    atk1_req = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    fcx = 1'b0;
    exp_q.push_back(pack(S_IDLE, 0, fcx, 0, 0, 0));
    sb_check("async_reset");
    @(posedge clk);
    #1;
    exp_q.push_back(pack(S_IDLE, 0, fcx, 0, 0, 0));
    sb_check("reset_next_cycle");
    @(negedge clk);
    reset = 1'b0;
    step(P_NONE, S_IDLE, 0, fcx, 0, 0, 0, "pending_discarded");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
